// File: rtl/mm_result_collector.sv
// mm_result_collector: captures the MM result stream, checks its row/column shape and serves
// the product back in row-major order. Optional per-row sum outputs: MM_COLLECT_ROW_SUM_EN.
module mm_result_collector #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [3:0]               exp_rows,
    input  logic                     valid,
    input  logic                     is_legal,
    input  logic                     change_row,
    input  logic [DATA_W-1:0]        out_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     rd_last,
    output logic                     done,
    output logic                     illegal,
    output logic                     shape_err,
    output logic                     overflow,
    output logic [3:0]               rows,
    output logic [3:0]               cols
`ifdef MM_COLLECT_ROW_SUM_EN
    ,
    output logic signed [DATA_W+3:0] row_sum,
    output logic                     row_sum_valid
`endif
);

    // One extra bit so a full buffer (count == DEPTH) is representable.
    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StCollect, StReadout} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [3:0]        exp_rows_q;
    logic [3:0]        rows_q, cols_q, col_cnt_q;
    logic [CntW-1:0]   count_q, rd_ptr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q, rd_last_q;
    logic              done_q, illegal_q, shape_err_q, overflow_q;

    logic start_ok, beat, beat_legal, beat_illegal, row_end, last_row, has_room, rd_accept;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    assign start_ok     = start && (exp_rows != 4'd0);
    assign beat         = (state_q == StCollect) && valid;
    assign beat_legal   = beat && is_legal;
    assign beat_illegal = beat && !is_legal;
    assign row_end      = beat_legal && change_row;
    assign last_row     = row_end && (sat_inc(rows_q) == exp_rows_q);
    assign has_room     = count_q < DepthCnt;
    assign rd_accept    = (state_q == StReadout) && rd_en && (rd_ptr_q < count_q);

    always_comb begin
        state_d = state_q;
        if (start_ok) begin
            state_d = StCollect;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StIdle;
                StCollect: if (beat_illegal || last_row) state_d = StReadout;
                // An illegal product never produces rd_last, so it parks here until start.
                StReadout: if (rd_last_q) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer storage carries no reset; count_q alone defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (beat_legal && has_room) begin
            mem[count_q[ADDR_W-1:0]] <= out_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_rows_q  <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            col_cnt_q   <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            shape_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (start_ok) begin
            exp_rows_q  <= exp_rows;
            rows_q      <= '0;
            cols_q      <= '0;
            col_cnt_q   <= '0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            shape_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;

            if (beat_illegal) begin
                illegal_q <= 1'b1;
                done_q    <= 1'b1;
                rows_q    <= '0;
                cols_q    <= '0;
                count_q   <= '0;
            end else if (beat_legal) begin
                if (has_room) begin
                    count_q <= count_q + CntW'(1);
                end else begin
                    overflow_q <= 1'b1;
                end
                if (change_row) begin
                    // rows_q == 0 means this beat closes the first row.
                    if (rows_q == 4'd0) begin
                        cols_q <= sat_inc(col_cnt_q);
                    end else if (sat_inc(col_cnt_q) != cols_q) begin
                        shape_err_q <= 1'b1;
                    end
                    rows_q    <= sat_inc(rows_q);
                    col_cnt_q <= '0;
                    if (last_row) begin
                        done_q <= 1'b1;
                    end
                end else begin
                    col_cnt_q <= sat_inc(col_cnt_q);
                end
            end

            if (rd_accept) begin
                rd_data_q  <= mem[rd_ptr_q[ADDR_W-1:0]];
                rd_valid_q <= 1'b1;
                rd_last_q  <= (rd_ptr_q == count_q - CntW'(1));
                rd_ptr_q   <= rd_ptr_q + CntW'(1);
            end

            if ((state_q == StReadout) && rd_last_q) begin
                done_q <= 1'b0;
            end
        end
    end

`ifdef MM_COLLECT_ROW_SUM_EN
    logic signed [DATA_W+3:0] acc_q, acc_next, row_sum_q;
    logic                     row_sum_valid_q;

    assign acc_next = acc_q + $signed({{4{out_data[DATA_W-1]}}, out_data});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q           <= '0;
            row_sum_q       <= '0;
            row_sum_valid_q <= 1'b0;
        end else if (start_ok) begin
            acc_q           <= '0;
            row_sum_q       <= '0;
            row_sum_valid_q <= 1'b0;
        end else begin
            row_sum_valid_q <= 1'b0;
            if (row_end) begin
                row_sum_q       <= acc_next;
                row_sum_valid_q <= 1'b1;
                acc_q           <= '0;
            end else if (beat_legal) begin
                acc_q <= acc_next;
            end
        end
    end

    assign row_sum       = row_sum_q;
    assign row_sum_valid = row_sum_valid_q;
`endif

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;
    assign illegal   = illegal_q;
    assign shape_err = shape_err_q;
    assign overflow  = overflow_q;
    assign rows      = rows_q;
    assign cols      = cols_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Directed self-checking bench for mm_result_collector: a default-depth instance plus a
// DEPTH=4 instance sharing the same stimulus for the overflow scenario.
module tb_mm_result_collector;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   exp_rows = 4'd0;
    logic         valid = 1'b0;
    logic         is_legal = 1'b0;
    logic         change_row = 1'b0;
    logic [W-1:0] out_data = '0;
    logic         rd_en = 1'b0;

    logic [W-1:0] rd_data_m, rd_data_s;
    logic         rd_valid_m, rd_last_m, done_m, illegal_m, shape_err_m, overflow_m;
    logic         rd_valid_s, rd_last_s, done_s, illegal_s, shape_err_s, overflow_s;
    logic [3:0]   rows_m, cols_m, rows_s, cols_s;
`ifdef MM_COLLECT_ROW_SUM_EN
    logic signed [W+3:0] row_sum_m, row_sum_s;
    logic                row_sum_valid_m, row_sum_valid_s;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mm_result_collector dut_main (
        .clk(clk), .rst(rst), .start(start), .exp_rows(exp_rows), .valid(valid),
        .is_legal(is_legal), .change_row(change_row), .out_data(out_data), .rd_en(rd_en),
        .rd_data(rd_data_m), .rd_valid(rd_valid_m), .rd_last(rd_last_m), .done(done_m),
        .illegal(illegal_m), .shape_err(shape_err_m), .overflow(overflow_m),
        .rows(rows_m), .cols(cols_m)
`ifdef MM_COLLECT_ROW_SUM_EN
        , .row_sum(row_sum_m), .row_sum_valid(row_sum_valid_m)
`endif
    );

    mm_result_collector #(.DATA_W(20), .DEPTH(4), .ADDR_W(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .exp_rows(exp_rows), .valid(valid),
        .is_legal(is_legal), .change_row(change_row), .out_data(out_data), .rd_en(rd_en),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s), .rd_last(rd_last_s), .done(done_s),
        .illegal(illegal_s), .shape_err(shape_err_s), .overflow(overflow_s),
        .rows(rows_s), .cols(cols_s)
`ifdef MM_COLLECT_ROW_SUM_EN
        , .row_sum(row_sum_s), .row_sum_valid(row_sum_valid_s)
`endif
    );

    task automatic idle_cycle();
        @(negedge clk);
        start = 1'b0; valid = 1'b0; is_legal = 1'b0; change_row = 1'b0; rd_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] n);
        @(negedge clk);
        start = 1'b1; exp_rows = n; valid = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input logic cr, input logic lg);
        @(negedge clk);
        valid = 1'b1; out_data = d; change_row = cr; is_legal = lg;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (done_m !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done_m); end
        n_cmp++; if ({illegal_m, shape_err_m, overflow_m} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %0b want 000", {illegal_m, shape_err_m, overflow_m}); end
        n_cmp++; if ({rows_m, cols_m} !== 8'h00) begin n_err++; $display("FAIL reset_rows_cols: got %0h want 00", {rows_m, cols_m}); end
        n_cmp++; if ({rd_valid_m, rd_last_m, rd_data_m} !== '0) begin n_err++; $display("FAIL reset_rd: got %0h want 0", {rd_valid_m, rd_last_m, rd_data_m}); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_d [4];
        exp_d[0] = 20'd5; exp_d[1] = 20'hFFFF9; exp_d[2] = 20'd100; exp_d[3] = 20'd0;
        pulse_start(4'd2);
        drive_beat(20'd5, 1'b0, 1'b1);
        drive_beat(20'hFFFF9, 1'b1, 1'b1);
        drive_beat(20'd100, 1'b0, 1'b1);
        drive_beat(20'd0, 1'b1, 1'b1);
        idle_cycle();
        n_cmp++; if (done_m !== 1'b1) begin n_err++; $display("FAIL basic_done: got %0b want 1", done_m); end
        n_cmp++; if (rows_m !== 4'd2) begin n_err++; $display("FAIL basic_rows: got %0d want 2", rows_m); end
        n_cmp++; if (cols_m !== 4'd2) begin n_err++; $display("FAIL basic_cols: got %0d want 2", cols_m); end
        n_cmp++; if ({illegal_m, shape_err_m, overflow_m} !== 3'b000) begin n_err++; $display("FAIL basic_flags: got %0b want 000", {illegal_m, shape_err_m, overflow_m}); end
        @(negedge clk);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (rd_valid_m !== 1'b1) begin n_err++; $display("FAIL basic_rd_valid[%0d]: got %0b want 1", i, rd_valid_m); end
            n_cmp++; if (rd_data_m !== exp_d[i]) begin n_err++; $display("FAIL basic_rd_data[%0d]: got %0h want %0h", i, rd_data_m, exp_d[i]); end
            n_cmp++; if (rd_last_m !== (i == 3)) begin n_err++; $display("FAIL basic_rd_last[%0d]: got %0b want %0b", i, rd_last_m, (i == 3)); end
        end
        rd_en = 1'b0;
        idle_cycle();
        n_cmp++; if (done_m !== 1'b0) begin n_err++; $display("FAIL basic_done_after_read: got %0b want 0", done_m); end
        n_cmp++; if (rd_valid_m !== 1'b0) begin n_err++; $display("FAIL basic_rd_valid_end: got %0b want 0", rd_valid_m); end
        n_cmp++; if (rows_m !== 4'd2) begin n_err++; $display("FAIL basic_rows_held: got %0d want 2", rows_m); end
        // Beats while idle must be ignored entirely.
        drive_beat(20'd9, 1'b1, 1'b0);
        idle_cycle();
        n_cmp++; if (illegal_m !== 1'b0) begin n_err++; $display("FAIL idle_beat_illegal: got %0b want 0", illegal_m); end
        n_cmp++; if ({done_m, rows_m} !== {1'b0, 4'd2}) begin n_err++; $display("FAIL idle_beat_state: got %0h want 2", {done_m, rows_m}); end
    endtask

    task automatic test_illegal();
        pulse_start(4'd3);
        drive_beat(20'h00123, 1'b0, 1'b0);
        idle_cycle();
        n_cmp++; if (illegal_m !== 1'b1) begin n_err++; $display("FAIL illegal_flag: got %0b want 1", illegal_m); end
        n_cmp++; if (done_m !== 1'b1) begin n_err++; $display("FAIL illegal_done: got %0b want 1", done_m); end
        n_cmp++; if ({rows_m, cols_m} !== 8'h00) begin n_err++; $display("FAIL illegal_rows_cols: got %0h want 00", {rows_m, cols_m}); end
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++; if (rd_valid_m !== 1'b0) begin n_err++; $display("FAIL illegal_rd_valid: got %0b want 0", rd_valid_m); end
        idle_cycle();
        n_cmp++; if (done_m !== 1'b1) begin n_err++; $display("FAIL illegal_done_held: got %0b want 1", done_m); end
        // exp_rows=0 start is ignored, so the illegal result stays visible.
        pulse_start(4'd0);
        idle_cycle();
        n_cmp++; if ({illegal_m, done_m} !== 2'b11) begin n_err++; $display("FAIL zero_start_ignored: got %0b want 11", {illegal_m, done_m}); end
    endtask

    task automatic test_ragged();
        logic [W-1:0] exp_d [5];
        for (int i = 0; i < 5; i++) exp_d[i] = W'(10 + i);
        pulse_start(4'd2);
        drive_beat(20'd10, 1'b0, 1'b1);
        drive_beat(20'd11, 1'b0, 1'b1);
        drive_beat(20'd12, 1'b1, 1'b1);
        drive_beat(20'd13, 1'b0, 1'b1);
        drive_beat(20'd14, 1'b1, 1'b1);
        idle_cycle();
        n_cmp++; if (shape_err_m !== 1'b1) begin n_err++; $display("FAIL ragged_shape_err: got %0b want 1", shape_err_m); end
        n_cmp++; if (done_m !== 1'b1) begin n_err++; $display("FAIL ragged_done: got %0b want 1", done_m); end
        n_cmp++; if ({rows_m, cols_m} !== {4'd2, 4'd3}) begin n_err++; $display("FAIL ragged_rows_cols: got %0h want 23", {rows_m, cols_m}); end
        @(negedge clk);
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if ({rd_valid_m, rd_data_m} !== {1'b1, exp_d[i]}) begin n_err++; $display("FAIL ragged_rd[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, rd_valid_m, rd_data_m, exp_d[i]); end
            n_cmp++; if (rd_last_m !== (i == 4)) begin n_err++; $display("FAIL ragged_rd_last[%0d]: got %0b want %0b", i, rd_last_m, (i == 4)); end
        end
        rd_en = 1'b0;
        idle_cycle();
    endtask

    task automatic test_overflow();
        pulse_start(4'd1);
        for (int i = 1; i <= 6; i++) drive_beat(W'(i), (i == 6), 1'b1);
        idle_cycle();
        n_cmp++; if (overflow_s !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b want 1", overflow_s); end
        n_cmp++; if (overflow_m !== 1'b0) begin n_err++; $display("FAIL ovf_flag_deep: got %0b want 0", overflow_m); end
        n_cmp++; if ({rows_s, cols_s} !== {4'd1, 4'd6}) begin n_err++; $display("FAIL ovf_rows_cols: got %0h want 16", {rows_s, cols_s}); end
        n_cmp++; if (done_s !== 1'b1) begin n_err++; $display("FAIL ovf_done: got %0b want 1", done_s); end
        @(negedge clk);
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                n_cmp++; if ({rd_valid_s, rd_data_s} !== {1'b1, W'(i + 1)}) begin n_err++; $display("FAIL ovf_rd[%0d]: got v=%0b d=%0h want v=1 d=%0h", i, rd_valid_s, rd_data_s, i + 1); end
                n_cmp++; if (rd_last_s !== (i == 3)) begin n_err++; $display("FAIL ovf_rd_last[%0d]: got %0b want %0b", i, rd_last_s, (i == 3)); end
            end else begin
                n_cmp++; if (rd_valid_s !== 1'b0) begin n_err++; $display("FAIL ovf_rd_past_end: got %0b want 0", rd_valid_s); end
            end
        end
        rd_en = 1'b0;
        idle_cycle();
    endtask

    task automatic test_abort();
        pulse_start(4'd3);
        drive_beat(20'd7, 1'b0, 1'b1);
        drive_beat(20'd8, 1'b1, 1'b1);
        drive_beat(20'd9, 1'b0, 1'b1);
        pulse_start(4'd1);
        drive_beat(20'hFFFFF, 1'b1, 1'b1);
        idle_cycle();
        n_cmp++; if ({rows_m, cols_m} !== {4'd1, 4'd1}) begin n_err++; $display("FAIL abort_rows_cols: got %0h want 11", {rows_m, cols_m}); end
        n_cmp++; if ({done_m, shape_err_m, overflow_m, illegal_m} !== 4'b1000) begin n_err++; $display("FAIL abort_flags: got %0b want 1000", {done_m, shape_err_m, overflow_m, illegal_m}); end
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++; if ({rd_valid_m, rd_last_m, rd_data_m} !== {2'b11, 20'hFFFFF}) begin n_err++; $display("FAIL abort_rd: got v=%0b l=%0b d=%0h want v=1 l=1 d=fffff", rd_valid_m, rd_last_m, rd_data_m); end
        idle_cycle();
        n_cmp++; if (done_m !== 1'b0) begin n_err++; $display("FAIL abort_done_end: got %0b want 0", done_m); end
    endtask

    task automatic test_reset_in_readout();
        pulse_start(4'd1);
        drive_beat(20'd1, 1'b0, 1'b1);
        drive_beat(20'd2, 1'b1, 1'b1);
        idle_cycle();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++; if ({rd_valid_m, rd_data_m} !== {1'b1, 20'd1}) begin n_err++; $display("FAIL rst_pre_read: got v=%0b d=%0h want v=1 d=1", rd_valid_m, rd_data_m); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({done_m, rows_m, cols_m} !== 9'd0) begin n_err++; $display("FAIL rst_async_state: got %0h want 0", {done_m, rows_m, cols_m}); end
        n_cmp++; if ({rd_valid_m, rd_last_m, rd_data_m} !== '0) begin n_err++; $display("FAIL rst_async_rd: got %0h want 0", {rd_valid_m, rd_last_m, rd_data_m}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        n_cmp++; if (rd_valid_m !== 1'b0) begin n_err++; $display("FAIL rst_rd_ignored: got %0b want 0", rd_valid_m); end
    endtask

`ifdef MM_COLLECT_ROW_SUM_EN
    task automatic test_row_sum();
        pulse_start(4'd1);
        drive_beat(20'h7FFFF, 1'b0, 1'b1);
        drive_beat(20'h7FFFF, 1'b1, 1'b1);
        idle_cycle();
        n_cmp++; if (row_sum_valid_m !== 1'b1) begin n_err++; $display("FAIL rowsum_valid: got %0b want 1", row_sum_valid_m); end
        n_cmp++; if (row_sum_m !== 24'sd1048574) begin n_err++; $display("FAIL rowsum_value: got %0d want 1048574", row_sum_m); end
        idle_cycle();
        n_cmp++; if (row_sum_valid_m !== 1'b0) begin n_err++; $display("FAIL rowsum_pulse: got %0b want 0", row_sum_valid_m); end
        pulse_start(4'd1);
        n_cmp++; if ({row_sum_valid_m, row_sum_m} !== '0) begin n_err++; $display("FAIL rowsum_start_clear: got %0h want 0", {row_sum_valid_m, row_sum_m}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_ragged();
        test_overflow();
        test_abort();
`ifdef MM_COLLECT_ROW_SUM_EN
        test_row_sum();
`endif
        test_reset_in_readout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
